// File: rtl/mux_n_1_scan.sv
// N:1 multiplexer with registered output, manual select or round-robin scan with per-channel dwell.
// Optional scan mask port enabled by defining MUX_N_1_SCAN_MASK_EN.
module mux_n_1_scan #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int DWELL = 1,
    localparam int SW   = $clog2(N),
    localparam int DCW  = $clog2(DWELL) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_bus,
    input  logic [SW-1:0]   sel,
    input  logic            en,
    input  logic            mode,
`ifdef MUX_N_1_SCAN_MASK_EN
    input  logic [N-1:0]    mask,
`endif
    output logic [W-1:0]    y,
    output logic [SW-1:0]   ch,
    output logic            valid,
    output logic            wrap
);

    localparam logic [SW-1:0]  PTR_LAST = SW'(N - 1);
    localparam logic [DCW-1:0] CNT_LAST = DCW'(DWELL - 1);

    logic [SW-1:0]  ptr, ptr_n;
    logic [DCW-1:0] cnt, cnt_n;
    logic [W-1:0]   y_n;
    logic [SW-1:0]  ch_n;
    logic           valid_n, wrap_n;
    logic [W-1:0]   sel_data, ptr_data;
    logic           sel_ok;

    // Loop-based pick keeps out-of-range indices (non power-of-2 N) from slicing past in_bus.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus, input logic [SW-1:0] idx);
        pick = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx == SW'(k)) pick = bus[k*W +: W];
        end
    endfunction

    assign sel_data = pick(in_bus, sel);
    assign ptr_data = pick(in_bus, ptr);
    assign sel_ok   = (int'(sel) < N);

`ifdef MUX_N_1_SCAN_MASK_EN
    logic [SW-1:0] nxt_ptr;
    logic          nxt_found, nxt_wrap;
    logic [SW-1:0] probe;

    // Descending offsets so the nearest enabled channel after ptr is the last one written.
    always_comb begin
        nxt_ptr   = ptr;
        nxt_found = 1'b0;
        nxt_wrap  = 1'b0;
        probe     = '0;
        for (int unsigned off = N; off >= 1; off--) begin
            probe = SW'((int'(ptr) + off) % N);
            if (mask[probe]) begin
                nxt_ptr   = probe;
                nxt_found = 1'b1;
                nxt_wrap  = ((int'(ptr) + off) >= N);
            end
        end
    end
`endif

    always_comb begin
        y_n     = y;
        ch_n    = ch;
        valid_n = 1'b0;
        wrap_n  = 1'b0;
        ptr_n   = ptr;
        cnt_n   = cnt;
        if (en) begin
            if (!mode) begin
                ptr_n = '0;
                cnt_n = '0;
                ch_n  = sel;
                if (sel_ok) begin
                    y_n     = sel_data;
                    valid_n = 1'b1;
                end else begin
                    y_n     = '0;
                end
            end else begin
                ch_n = ptr;
`ifdef MUX_N_1_SCAN_MASK_EN
                if (!nxt_found) begin
                    y_n   = '0;
                    cnt_n = '0;
                end else begin
                    y_n     = ptr_data;
                    valid_n = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt_n  = '0;
                        ptr_n  = nxt_ptr;
                        wrap_n = nxt_wrap;
                    end else begin
                        cnt_n = cnt + DCW'(1);
                    end
                end
`else
                y_n     = ptr_data;
                valid_n = 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_n  = '0;
                    ptr_n  = (ptr == PTR_LAST) ? '0 : ptr + SW'(1);
                    wrap_n = (ptr == PTR_LAST);
                end else begin
                    cnt_n = cnt + DCW'(1);
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y     <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            y     <= y_n;
            ch    <= ch_n;
            valid <= valid_n;
            wrap  <= wrap_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

endmodule
